demux_1to16_32bit_buf: RTL and testbench

//  Write-side counterpart of the 16:1 32-bit select mux: routes one 32-bit word to one of 16 output channels.

---
 rtl/demux_pkg.sv | 28 ++
 rtl/demux_1to16_32bit_buf_if.sv | 29 ++
 rtl/demux_slot.sv | 34 +++
 rtl/demux_1to16_32bit_buf.sv | 74 +++++++
 tb/tb_demux_1to16_32bit_buf.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared widths, data type and decode/count helpers for the 1:16 demux
package demux_pkg;

    localparam int DATA_W = 32;
    localparam int NCH    = 16;
    localparam int SEL_W  = 4;

    typedef logic [DATA_W-1:0] data_t;

    // One-hot decode of a channel index.
    function automatic logic [NCH-1:0] onehot16(input logic [SEL_W-1:0] sel);
        logic [NCH-1:0] hot;
        hot      = '0;
        hot[sel] = 1'b1;
        return hot;
    endfunction

    // Number of set bits; used for occupancy increments and decrements.
    function automatic logic [SEL_W:0] popcount(input logic [NCH-1:0] v);
        logic [SEL_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt = cnt + {{SEL_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/demux_1to16_32bit_buf_if.sv
// rtl/demux_1to16_32bit_buf_if.sv - producer/consumer bus of the demux (in_bcast only with DEMUX_BCAST_EN)
interface demux_1to16_32bit_buf_if;
    import demux_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [SEL_W-1:0]      in_sel;
    data_t                 in_data;
`ifdef DEMUX_BCAST_EN
    logic                  in_bcast;
`endif
    logic [NCH-1:0]        out_valid;
    logic [NCH*DATA_W-1:0] out_data;
    logic [NCH-1:0]        out_ack;
    logic [SEL_W:0]        out_occ;

`ifdef DEMUX_BCAST_EN
    modport master (output in_valid, in_sel, in_data, in_bcast, out_ack,
                    input  in_ready, out_valid, out_data, out_occ);
    modport slave  (input  in_valid, in_sel, in_data, in_bcast, out_ack,
                    output in_ready, out_valid, out_data, out_occ);
`else
    modport master (output in_valid, in_sel, in_data, out_ack,
                    input  in_ready, out_valid, out_data, out_occ);
    modport slave  (input  in_valid, in_sel, in_data, out_ack,
                    output in_ready, out_valid, out_data, out_occ);
`endif

endinterface

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry holding register for a single output channel
module demux_slot
    import demux_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  ack,
    input  data_t data_in,
    output logic  valid,
    output data_t data
);

    // Load wins over ack so a refill on the ack cycle leaves no bubble; an ack on an empty slot is a no-op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (ack) begin
            valid <= 1'b0;
        end
    end

    // Data is only written on load and keeps its last value after the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= data_in;
        end
    end

endmodule

// File: rtl/demux_1to16_32bit_buf.sv
// rtl/demux_1to16_32bit_buf.sv - 1:16 32-bit demux with per-channel holding registers; DEMUX_BCAST_EN adds broadcast
module demux_1to16_32bit_buf
    import demux_pkg::*;
(
    input logic                     clk,
    input logic                     rst_n,
    demux_1to16_32bit_buf_if.slave  bus
);

    logic [NCH-1:0]        valid_q;
    data_t                 slot_data [NCH];
    logic [NCH-1:0]        slot_free;
    logic [NCH-1:0]        sel_hot;
    logic [NCH-1:0]        load;
    logic                  accept;
    logic [SEL_W:0]        occ_q;
    logic [SEL_W:0]        occ_inc;
    logic [SEL_W:0]        occ_dec;
    logic [NCH*DATA_W-1:0] out_data_w;

    assign sel_hot   = onehot16(bus.in_sel);
    assign slot_free = ~valid_q | bus.out_ack;

`ifdef DEMUX_BCAST_EN
    logic bcast;
    assign bcast        = bus.in_valid & bus.in_bcast;
    assign bus.in_ready = bcast ? &slot_free : slot_free[bus.in_sel];
    assign accept       = bus.in_valid & bus.in_ready;
    assign load         = accept ? (bcast ? {NCH{1'b1}} : sel_hot) : '0;
`else
    assign bus.in_ready = slot_free[bus.in_sel];
    assign accept       = bus.in_valid & bus.in_ready;
    assign load         = {NCH{accept}} & sel_hot;
`endif

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_slot u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load[k]),
            .ack     (bus.out_ack[k]),
            .data_in (bus.in_data),
            .valid   (valid_q[k]),
            .data    (slot_data[k])
        );
    end

    // Pack the per-channel registers onto the flat output bus.
    always_comb begin
        out_data_w = '0;
        for (int k = 0; k < NCH; k++) begin
            out_data_w[k*DATA_W +: DATA_W] = slot_data[k];
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = out_data_w;

    // Slots filled from empty add one; acked slots that are not refilled the same cycle remove one.
    assign occ_inc = popcount(load & ~valid_q);
    assign occ_dec = popcount(bus.out_ack & valid_q & ~load);

    // Registered occupancy count; stays within 0..NCH because it tracks valid_q exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + occ_inc - occ_dec;
        end
    end

    assign bus.out_occ = occ_q;

endmodule

// File: tb/tb_demux_1to16_32bit_buf.sv
// tb/tb_demux_1to16_32bit_buf.sv - directed self-checking bench for the demux (broadcast test with DEMUX_BCAST_EN)
module tb_demux_1to16_32bit_buf;
    import demux_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    demux_1to16_32bit_buf_if dif ();

    demux_1to16_32bit_buf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] slot(input int k);
        return dif.out_data[k*32 +: 32];
    endfunction

    task automatic idle_inputs();
        dif.in_valid = 1'b0;
        dif.in_sel   = '0;
        dif.in_data  = '0;
        dif.out_ack  = '0;
`ifdef DEMUX_BCAST_EN
        dif.in_bcast = 1'b0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one single-channel write at a negedge; returns at the following negedge with inputs idle.
    task automatic write_one(input logic [3:0] sel, input logic [31:0] data);
        dif.in_valid = 1'b1;
        dif.in_sel   = sel;
        dif.in_data  = data;
        @(negedge clk);
        dif.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (dif.out_valid !== 16'h0) begin n_fail++; $display("FAIL reset_init_valid got %h want %h", dif.out_valid, 16'h0); end
        n_cmp++; if (dif.out_occ !== 5'd0) begin n_fail++; $display("FAIL reset_init_occ got %0d want 0", dif.out_occ); end
        write_one(4'd9, 32'hCAFEF00D);
        write_one(4'd1, 32'h01010101);
        // Hold a pending write to ch9 (full) and assert reset between edges.
        dif.in_valid = 1'b1;
        dif.in_sel   = 4'd9;
        dif.in_data  = 32'h99999999;
        #1;
        n_cmp++; if (dif.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pre_ready got %b want 0", dif.in_ready); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (dif.out_valid !== 16'h0) begin n_fail++; $display("FAIL reset_async_valid got %h want %h", dif.out_valid, 16'h0); end
        n_cmp++; if (dif.out_occ !== 5'd0) begin n_fail++; $display("FAIL reset_async_occ got %0d want 0", dif.out_occ); end
        n_cmp++; if (dif.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_async_ready got %b want 1", dif.in_ready); end
        n_cmp++; if (slot(9) !== 32'h0) begin n_fail++; $display("FAIL reset_slot9 got %h want 0", slot(9)); end
        n_cmp++; if (dif.out_data !== '0) begin n_fail++; $display("FAIL reset_all_slots not zero"); end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        do_reset();
        dif.in_valid = 1'b1;
        dif.in_sel   = 4'd5;
        dif.in_data  = 32'hDEADBEEF;
        #1;
        n_cmp++; if (dif.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", dif.in_ready); end
        n_cmp++; if (dif.out_valid !== 16'h0) begin n_fail++; $display("FAIL single_pre_valid got %h want 0", dif.out_valid); end
        @(negedge clk);
        dif.in_valid = 1'b0;
        n_cmp++; if (dif.out_valid !== 16'h0020) begin n_fail++; $display("FAIL single_valid got %h want %h", dif.out_valid, 16'h0020); end
        n_cmp++; if (slot(5) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_slot5 got %h want %h", slot(5), 32'hDEADBEEF); end
        n_cmp++; if (dif.out_occ !== 5'd1) begin n_fail++; $display("FAIL single_occ got %0d want 1", dif.out_occ); end
    endtask

    task automatic test_backpressure();
        do_reset();
        write_one(4'd3, 32'h33333333);
        dif.in_valid = 1'b1;
        dif.in_sel   = 4'd3;
        dif.in_data  = 32'hAAAA5555;
        #1;
        n_cmp++; if (dif.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got %b want 0", dif.in_ready); end
        @(negedge clk);
        n_cmp++; if (slot(3) !== 32'h33333333) begin n_fail++; $display("FAIL bp_slot3_held got %h want %h", slot(3), 32'h33333333); end
        n_cmp++; if (dif.out_valid !== 16'h0008) begin n_fail++; $display("FAIL bp_valid_held got %h want %h", dif.out_valid, 16'h0008); end
        dif.out_ack = 16'h0008;
        #1;
        n_cmp++; if (dif.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_ack got %b want 1", dif.in_ready); end
        @(negedge clk);
        idle_inputs();
        n_cmp++; if (slot(3) !== 32'hAAAA5555) begin n_fail++; $display("FAIL bp_slot3_new got %h want %h", slot(3), 32'hAAAA5555); end
        n_cmp++; if (dif.out_valid !== 16'h0008) begin n_fail++; $display("FAIL bp_valid_nobubble got %h want %h", dif.out_valid, 16'h0008); end
        n_cmp++; if (dif.out_occ !== 5'd1) begin n_fail++; $display("FAIL bp_occ got %0d want 1", dif.out_occ); end
    endtask

    task automatic test_fill_all();
        logic [15:0] exp_valid;
        do_reset();
        exp_valid = '0;
        for (int i = 0; i < 16; i++) begin
            dif.in_valid = 1'b1;
            dif.in_sel   = 4'(i);
            dif.in_data  = 32'h10000000 + 32'(i);
            #1;
            n_cmp++; if (dif.in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready ch%0d got %b want 1", i, dif.in_ready); end
            @(negedge clk);
            exp_valid[i] = 1'b1;
            n_cmp++; if (dif.out_occ !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_occ ch%0d got %0d want %0d", i, dif.out_occ, i + 1); end
            n_cmp++; if (dif.out_valid !== exp_valid) begin n_fail++; $display("FAIL fill_valid ch%0d got %h want %h", i, dif.out_valid, exp_valid); end
        end
        dif.in_valid = 1'b0;
        n_cmp++; if (slot(10) !== 32'h1000000A) begin n_fail++; $display("FAIL fill_slot10 got %h want %h", slot(10), 32'h1000000A); end
        dif.out_ack = 16'hFFFF;
        @(negedge clk);
        dif.out_ack = 16'h0;
        n_cmp++; if (dif.out_valid !== 16'h0) begin n_fail++; $display("FAIL drain_valid got %h want 0", dif.out_valid); end
        n_cmp++; if (dif.out_occ !== 5'd0) begin n_fail++; $display("FAIL drain_occ got %0d want 0", dif.out_occ); end
        n_cmp++; if (slot(15) !== 32'h1000000F) begin n_fail++; $display("FAIL drain_slot15_kept got %h want %h", slot(15), 32'h1000000F); end
    endtask

    task automatic test_spurious_ack();
        do_reset();
        write_one(4'd2, 32'h22222222);
        dif.out_ack = 16'h8000;
        @(negedge clk);
        dif.out_ack = 16'h0;
        n_cmp++; if (dif.out_valid !== 16'h0004) begin n_fail++; $display("FAIL spur_valid got %h want %h", dif.out_valid, 16'h0004); end
        n_cmp++; if (dif.out_occ !== 5'd1) begin n_fail++; $display("FAIL spur_occ got %0d want 1", dif.out_occ); end
        n_cmp++; if (slot(15) !== 32'h0) begin n_fail++; $display("FAIL spur_slot15 got %h want 0", slot(15)); end
    endtask

    task automatic test_multi_ack();
        do_reset();
        write_one(4'd0, 32'hA0A0A0A0);
        write_one(4'd4, 32'hA4A4A4A4);
        write_one(4'd8, 32'hA8A8A8A8);
        // Ack ch0 and ch8 while refilling ch4 (acked too): occ 3 -> 1.
        dif.out_ack  = 16'h0111;
        dif.in_valid = 1'b1;
        dif.in_sel   = 4'd4;
        dif.in_data  = 32'hB4B4B4B4;
        @(negedge clk);
        idle_inputs();
        n_cmp++; if (dif.out_valid !== 16'h0010) begin n_fail++; $display("FAIL multi_valid got %h want %h", dif.out_valid, 16'h0010); end
        n_cmp++; if (dif.out_occ !== 5'd1) begin n_fail++; $display("FAIL multi_occ got %0d want 1", dif.out_occ); end
        n_cmp++; if (slot(4) !== 32'hB4B4B4B4) begin n_fail++; $display("FAIL multi_slot4 got %h want %h", slot(4), 32'hB4B4B4B4); end
    endtask

`ifdef DEMUX_BCAST_EN
    task automatic test_bcast();
        do_reset();
        write_one(4'd7, 32'h77777777);
        dif.in_valid = 1'b1;
        dif.in_bcast = 1'b1;
        dif.in_sel   = 4'd0;
        dif.in_data  = 32'h12345678;
        #1;
        n_cmp++; if (dif.in_ready !== 1'b0) begin n_fail++; $display("FAIL bcast_ready_blocked got %b want 0", dif.in_ready); end
        @(negedge clk);
        n_cmp++; if (dif.out_valid !== 16'h0080) begin n_fail++; $display("FAIL bcast_valid_blocked got %h want %h", dif.out_valid, 16'h0080); end
        dif.out_ack = 16'h0080;
        #1;
        n_cmp++; if (dif.in_ready !== 1'b1) begin n_fail++; $display("FAIL bcast_ready_ack got %b want 1", dif.in_ready); end
        @(negedge clk);
        idle_inputs();
        n_cmp++; if (dif.out_valid !== 16'hFFFF) begin n_fail++; $display("FAIL bcast_valid got %h want %h", dif.out_valid, 16'hFFFF); end
        n_cmp++; if (dif.out_occ !== 5'd16) begin n_fail++; $display("FAIL bcast_occ got %0d want 16", dif.out_occ); end
        for (int k = 0; k < 16; k++) begin
            n_cmp++; if (slot(k) !== 32'h12345678) begin n_fail++; $display("FAIL bcast_slot%0d got %h want %h", k, slot(k), 32'h12345678); end
        end
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_backpressure();
        test_fill_all();
        test_spurious_ack();
        test_multi_ack();
`ifdef DEMUX_BCAST_EN
        test_bcast();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
